core_hazard_ctrl: RTL and testbench
===================================

Name: core_hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage Selen core (F, D, E, M, W).
- Consumes the decode-stage hazard class (HZRD_OTHER/BRNCH/JUMP/LOAD) and register fields produced by the control decoder.
- Tracks the instruction in E through an internal shadow register.
- Produces per-stage stall/kill and PC-redirect strobes for load-use, taken branch/jump, I-cache miss and D-cache wait.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
hz_dec_val_in  in  1  decode stage holds a valid instruction
hz_dec_cmd_in  in  2  hazard class of D instr: OTHER=00, BRNCH=01, JUMP=10, LOAD=11
hz_dec_rs1_in  in  REG_AW  D instr rs1
hz_dec_rs2_in  in  REG_AW  D instr rs2
hz_dec_rs1_use_in  in  1  D instr reads rs1
hz_dec_rs2_use_in  in  1  D instr reads rs2
hz_dec_rd_in  in  REG_AW  D instr rd
hz_dec_we_in  in  1  D instr writes register file
hz_exe_brnch_taken_in  in  1  branch condition true for E instr
hz_l1i_ack_in  in  1  fetch data valid this cycle
hz_l1d_req_in  in  1  M stage has outstanding L1D access
hz_l1d_ack_in  in  1  L1D completes access this cycle
hz_pc_stall_out  out  1  hold PC
hz_pc_redirect_out  out  1  PC takes E-stage target
hz_fd_stall_out  out  1  hold F/D register
hz_fd_kill_out  out  1  load bubble into F/D
hz_de_stall_out  out  1  hold D/E register
hz_de_kill_out  out  1  load bubble into D/E
hz_em_stall_out  out  1  hold E/M register
hz_mw_stall_out  out  1  hold M/W register
hz_mw_kill_out  out  1  suppress writeback of W this cycle

Behaviour:
- E shadow (exe_val, exe_cmd, exe_rd, exe_we) updates on clk when D/E advances.
  - Loads the D fields when not killed.
  - Loads exe_val=0, exe_cmd=OTHER when hz_de_kill_out=1.
  - Holds when hz_de_stall_out=1.
- FSM states RUN, MEM_WAIT.
  - RUN→MEM_WAIT when hz_l1d_req_in & !hz_l1d_ack_in.
  - MEM_WAIT→RUN on hz_l1d_ack_in.
- All outputs are combinational from state, shadow and inputs (zero latency), in this priority:
  1. D-cache wait (hz_l1d_req_in & !hz_l1d_ack_in, in either state):
     - All stall outputs =1, hz_mw_kill_out=1, all other kills =0, redirect=0.
     - The shadow holds, so a pending redirect or load-use fires after the ack.
  2. Redirect (exe_val & (exe_cmd==JUMP | exe_cmd==BRNCH & hz_exe_brnch_taken_in)):
     - hz_pc_redirect_out=1, hz_fd_kill_out=1, hz_de_kill_out=1; all stalls 0.
     - Two-bubble penalty.
  3. Load-use (exe_val & exe_cmd==LOAD & exe_we & exe_rd!=0 & hz_dec_val_in & ((rs1_use & rs1==exe_rd) | (rs2_use & rs2==exe_rd))):
     - hz_pc_stall_out=1, hz_fd_stall_out=1, hz_de_kill_out=1.
     - Exactly one bubble: the next cycle the shadow holds a bubble, so the condition self-clears.
  4. I-cache miss (!hz_l1i_ack_in): hz_pc_stall_out=1, hz_fd_kill_out=1.
  5. Otherwise all outputs 0.
- rd==0 never triggers load-use.
- Redirect overrides I-cache miss and load-use in the same cycle.
- Reset (rst_n low, asynchronous):
  - State RUN, exe_val=0, exe_cmd=OTHER, exe_rd=0, exe_we=0.
  - While rst_n=0: hz_fd_kill_out=1, hz_de_kill_out=1, hz_mw_kill_out=1, all other outputs 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; no stall persists after deassertion.

Optional Feature:
CORE_HZRD_PERF_EN
- Defined: adds outputs hz_perf_stall_cnt_out and hz_perf_flush_cnt_out, each CNT_W bits, reset to 0.
  - Stall counter +1 per cycle with hz_pc_stall_out=1.
  - Flush counter +1 per cycle with hz_pc_redirect_out=1.
  - Both saturate at all-ones.
- Undefined: ports and counters absent; other behaviour identical.

Test Plan:
1. Load-use: E=LOAD rd=5 we=1; D rs1=5 rs1_use=1, l1i_ack=1 → one cycle pc_stall=fd_stall=de_kill=1, then all 0. Same with rd=0 → no stall.
2. Taken branch: E=BRNCH, brnch_taken=1 → redirect=fd_kill=de_kill=1 for one cycle, next cycle 0. brnch_taken=0 → all 0. E=JUMP → redirect regardless of taken.
3. D-cache wait: l1d_req=1, ack=0 for 3 cycles while E=JUMP → 3 cycles all stalls=1, mw_kill=1, redirect=0. Ack cycle → redirect=1.
4. I-cache miss: l1i_ack=0 for 2 cycles, no other hazard → pc_stall=fd_kill=1 both cycles. Simultaneous load-use → load-use outputs win.
5. Reset mid-wait: rst_n low during MEM_WAIT → stalls drop asynchronously, kills=1. After release with l1i_ack=1 and no requests → all outputs 0.
6. CORE_HZRD_PERF_EN: 4 stall cycles + 2 redirects → stall_cnt=4, flush_cnt=2. Preloaded near-max counter saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/core_hazard_ctrl_if.sv
// Hazard controller handshake bundle: decode/execute/cache status in, stall/kill/redirect out.
// The master modport belongs to the pipeline and the slave modport to core_hazard_ctrl.
interface core_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              hz_dec_val_in;
  logic [1:0]        hz_dec_cmd_in;
  logic [REG_AW-1:0] hz_dec_rs1_in;
  logic [REG_AW-1:0] hz_dec_rs2_in;
  logic              hz_dec_rs1_use_in;
  logic              hz_dec_rs2_use_in;
  logic [REG_AW-1:0] hz_dec_rd_in;
  logic              hz_dec_we_in;
  logic              hz_exe_brnch_taken_in;
  logic              hz_l1i_ack_in;
  logic              hz_l1d_req_in;
  logic              hz_l1d_ack_in;

  logic              hz_pc_stall_out;
  logic              hz_pc_redirect_out;
  logic              hz_fd_stall_out;
  logic              hz_fd_kill_out;
  logic              hz_de_stall_out;
  logic              hz_de_kill_out;
  logic              hz_em_stall_out;
  logic              hz_mw_stall_out;
  logic              hz_mw_kill_out;

  modport master (
    output hz_dec_val_in, hz_dec_cmd_in, hz_dec_rs1_in, hz_dec_rs2_in,
           hz_dec_rs1_use_in, hz_dec_rs2_use_in, hz_dec_rd_in, hz_dec_we_in,
           hz_exe_brnch_taken_in, hz_l1i_ack_in, hz_l1d_req_in, hz_l1d_ack_in,
    input  hz_pc_stall_out, hz_pc_redirect_out, hz_fd_stall_out, hz_fd_kill_out,
           hz_de_stall_out, hz_de_kill_out, hz_em_stall_out, hz_mw_stall_out,
           hz_mw_kill_out
  );

  modport slave (
    input  hz_dec_val_in, hz_dec_cmd_in, hz_dec_rs1_in, hz_dec_rs2_in,
           hz_dec_rs1_use_in, hz_dec_rs2_use_in, hz_dec_rd_in, hz_dec_we_in,
           hz_exe_brnch_taken_in, hz_l1i_ack_in, hz_l1d_req_in, hz_l1d_ack_in,
    output hz_pc_stall_out, hz_pc_redirect_out, hz_fd_stall_out, hz_fd_kill_out,
           hz_de_stall_out, hz_de_kill_out, hz_em_stall_out, hz_mw_stall_out,
           hz_mw_kill_out
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// Selen 5-stage pipeline hazard/stall controller with an E-stage shadow of the decoded instr.
// Define CORE_HZRD_PERF_EN to add saturating stall/flush performance counters.
module core_hazard_ctrl #(
  parameter int unsigned REG_AW = 5
`ifdef CORE_HZRD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  core_hazard_ctrl_if.slave  hz_if
`ifdef CORE_HZRD_PERF_EN
  , output logic [CNT_W-1:0] hz_perf_stall_cnt_out
  , output logic [CNT_W-1:0] hz_perf_flush_cnt_out
`endif
);

  localparam logic [1:0] CmdOther = 2'b00;
  localparam logic [1:0] CmdBrnch = 2'b01;
  localparam logic [1:0] CmdJump  = 2'b10;
  localparam logic [1:0] CmdLoad  = 2'b11;

  typedef enum logic {StRun, StMemWait} state_e;

  state_e            state_q;
  logic              exe_val_q, exe_val_d;
  logic [1:0]        exe_cmd_q, exe_cmd_d;
  logic [REG_AW-1:0] exe_rd_q,  exe_rd_d;
  logic              exe_we_q,  exe_we_d;

  logic dwait, redirect_hit, load_use;
  logic pc_stall, pc_redirect, fd_stall, fd_kill, de_stall, de_kill, em_stall, mw_stall, mw_kill;

  assign dwait = hz_if.hz_l1d_req_in & ~hz_if.hz_l1d_ack_in;

  assign redirect_hit = exe_val_q & ((exe_cmd_q == CmdJump) |
                        ((exe_cmd_q == CmdBrnch) & hz_if.hz_exe_brnch_taken_in));

  assign load_use = exe_val_q & (exe_cmd_q == CmdLoad) & exe_we_q & (exe_rd_q != '0) &
                    hz_if.hz_dec_val_in &
                    ((hz_if.hz_dec_rs1_use_in & (hz_if.hz_dec_rs1_in == exe_rd_q)) |
                     (hz_if.hz_dec_rs2_use_in & (hz_if.hz_dec_rs2_in == exe_rd_q)));

  always_comb begin
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    fd_stall    = 1'b0;
    fd_kill     = 1'b0;
    de_stall    = 1'b0;
    de_kill     = 1'b0;
    em_stall    = 1'b0;
    mw_stall    = 1'b0;
    mw_kill     = 1'b0;
    if (!rst_n) begin
      fd_kill = 1'b1;
      de_kill = 1'b1;
      mw_kill = 1'b1;
    end else if (dwait) begin
      // Freeze everything; the shadow holds so a pending redirect/load-use fires after the ack.
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_stall = 1'b1;
      em_stall = 1'b1;
      mw_stall = 1'b1;
      mw_kill  = 1'b1;
    end else if (redirect_hit) begin
      pc_redirect = 1'b1;
      fd_kill     = 1'b1;
      de_kill     = 1'b1;
    end else if (load_use) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_kill  = 1'b1;
    end else if (!hz_if.hz_l1i_ack_in) begin
      pc_stall = 1'b1;
      fd_kill  = 1'b1;
    end
  end

  assign hz_if.hz_pc_stall_out    = pc_stall;
  assign hz_if.hz_pc_redirect_out = pc_redirect;
  assign hz_if.hz_fd_stall_out    = fd_stall;
  assign hz_if.hz_fd_kill_out     = fd_kill;
  assign hz_if.hz_de_stall_out    = de_stall;
  assign hz_if.hz_de_kill_out     = de_kill;
  assign hz_if.hz_em_stall_out    = em_stall;
  assign hz_if.hz_mw_stall_out    = mw_stall;
  assign hz_if.hz_mw_kill_out     = mw_kill;

  always_comb begin
    exe_val_d = exe_val_q;
    exe_cmd_d = exe_cmd_q;
    exe_rd_d  = exe_rd_q;
    exe_we_d  = exe_we_q;
    if (de_kill) begin
      exe_val_d = 1'b0;
      exe_cmd_d = CmdOther;
    end else if (!de_stall) begin
      exe_val_d = hz_if.hz_dec_val_in;
      exe_cmd_d = hz_if.hz_dec_cmd_in;
      exe_rd_d  = hz_if.hz_dec_rd_in;
      exe_we_d  = hz_if.hz_dec_we_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_val_q <= 1'b0;
      exe_cmd_q <= CmdOther;
      exe_rd_q  <= '0;
      exe_we_q  <= 1'b0;
    end else begin
      exe_val_q <= exe_val_d;
      exe_cmd_q <= exe_cmd_d;
      exe_rd_q  <= exe_rd_d;
      exe_we_q  <= exe_we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:     if (dwait) state_q <= StMemWait;
        StMemWait: if (hz_if.hz_l1d_ack_in) state_q <= StRun;
        default:   state_q <= StRun;
      endcase
    end
  end

`ifdef CORE_HZRD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pc_redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz_perf_stall_cnt_out = stall_cnt_q;
  assign hz_perf_flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed-vector bench for core_hazard_ctrl; expected output patterns are hand-derived constants.
// Output vector bit order: pc_stall redirect fd_stall fd_kill de_stall de_kill em_stall mw_stall mw_kill.
module tb_core_hazard_ctrl;

  localparam logic [8:0] ONone = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] OLu   = 9'b1_0_1_0_0_1_0_0_0;
  localparam logic [8:0] ORd   = 9'b0_1_0_1_0_1_0_0_0;
  localparam logic [8:0] ODw   = 9'b1_0_1_0_1_0_1_1_1;
  localparam logic [8:0] OIc   = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] ORst  = 9'b0_0_0_1_0_1_0_0_1;

  localparam logic [1:0] CmdOther = 2'b00;
  localparam logic [1:0] CmdBrnch = 2'b01;
  localparam logic [1:0] CmdJump  = 2'b10;
  localparam logic [1:0] CmdLoad  = 2'b11;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  core_hazard_ctrl_if #(.REG_AW(5)) hz_if ();

`ifdef CORE_HZRD_PERF_EN
  logic [2:0] stall_cnt;
  logic [2:0] flush_cnt;

  core_hazard_ctrl #(.REG_AW(5), .CNT_W(3)) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hz_if                 (hz_if),
    .hz_perf_stall_cnt_out (stall_cnt),
    .hz_perf_flush_cnt_out (flush_cnt)
  );
`else
  core_hazard_ctrl #(.REG_AW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (hz_if)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {hz_if.hz_pc_stall_out, hz_if.hz_pc_redirect_out, hz_if.hz_fd_stall_out,
                 hz_if.hz_fd_kill_out, hz_if.hz_de_stall_out, hz_if.hz_de_kill_out,
                 hz_if.hz_em_stall_out, hz_if.hz_mw_stall_out, hz_if.hz_mw_kill_out};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [8:0] want);
    #1;
    check(tag, {23'd0, outs}, {23'd0, want});
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic val, input logic [1:0] cmd, input logic [4:0] rd,
                         input logic we);
    hz_if.hz_dec_val_in = val;
    hz_if.hz_dec_cmd_in = cmd;
    hz_if.hz_dec_rd_in  = rd;
    hz_if.hz_dec_we_in  = we;
  endtask

  task automatic set_src(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2);
    hz_if.hz_dec_rs1_in     = rs1;
    hz_if.hz_dec_rs1_use_in = u1;
    hz_if.hz_dec_rs2_in     = rs2;
    hz_if.hz_dec_rs2_use_in = u2;
  endtask

  task automatic dec_idle();
    set_dec(1'b0, CmdOther, 5'd0, 1'b0);
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    dec_idle();
    hz_if.hz_exe_brnch_taken_in = 1'b0;
    hz_if.hz_l1i_ack_in         = 1'b1;
    hz_if.hz_l1d_req_in         = 1'b0;
    hz_if.hz_l1d_ack_in         = 1'b0;
    #2;
    expect_out("reset_outs", ORst);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_out("idle", ONone);

    // Load-use on rs1
    set_dec(1'b1, CmdLoad, 5'd5, 1'b1);
    expect_out("lu_bubble_e", ONone);
    cyc();
    set_dec(1'b1, CmdOther, 5'd6, 1'b1);
    set_src(5'd5, 1'b1, 5'd0, 1'b0);
    expect_out("lu_rs1", OLu);
    cyc();
    expect_out("lu_clear", ONone);
    cyc();
    dec_idle();

    // rd == 0 never stalls
    set_dec(1'b1, CmdLoad, 5'd0, 1'b1);
    cyc();
    set_dec(1'b1, CmdOther, 5'd1, 1'b1);
    set_src(5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("lu_rd0", ONone);
    cyc();

    // Load-use on rs2
    set_dec(1'b1, CmdLoad, 5'd7, 1'b1);
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_dec(1'b1, CmdOther, 5'd2, 1'b1);
    set_src(5'd3, 1'b1, 5'd7, 1'b1);
    expect_out("lu_rs2", OLu);
    cyc();
    expect_out("lu_rs2_clear", ONone);
    cyc();
    dec_idle();
    cyc();

    // Taken branch, then not-taken branch, then jump
    set_dec(1'b1, CmdBrnch, 5'd0, 1'b0);
    cyc();
    dec_idle();
    hz_if.hz_exe_brnch_taken_in = 1'b1;
    expect_out("br_taken", ORd);
    cyc();
    expect_out("br_after", ONone);
    hz_if.hz_exe_brnch_taken_in = 1'b0;
    set_dec(1'b1, CmdBrnch, 5'd0, 1'b0);
    cyc();
    dec_idle();
    expect_out("br_not_taken", ONone);
    set_dec(1'b1, CmdJump, 5'd0, 1'b0);
    cyc();
    dec_idle();
    expect_out("jump", ORd);
    cyc();

    // D-cache wait with a pending jump in E
    set_dec(1'b1, CmdJump, 5'd0, 1'b0);
    cyc();
    dec_idle();
    hz_if.hz_l1d_req_in = 1'b1;
    expect_out("dw_0", ODw);
    cyc();
    expect_out("dw_1", ODw);
    cyc();
    expect_out("dw_2", ODw);
    cyc();
    hz_if.hz_l1d_ack_in = 1'b1;
    expect_out("dw_ack_redirect", ORd);
    cyc();
    hz_if.hz_l1d_req_in = 1'b0;
    hz_if.hz_l1d_ack_in = 1'b0;
    expect_out("dw_done", ONone);

    // I-cache miss, then load-use during miss, then redirect during miss
    hz_if.hz_l1i_ack_in = 1'b0;
    expect_out("ic_0", OIc);
    cyc();
    expect_out("ic_1", OIc);
    set_dec(1'b1, CmdLoad, 5'd9, 1'b1);
    cyc();
    set_dec(1'b1, CmdOther, 5'd4, 1'b1);
    set_src(5'd9, 1'b1, 5'd0, 1'b0);
    expect_out("ic_vs_lu", OLu);
    cyc();
    dec_idle();
    set_dec(1'b1, CmdJump, 5'd0, 1'b0);
    cyc();
    dec_idle();
    expect_out("ic_vs_rd", ORd);
    hz_if.hz_l1i_ack_in = 1'b1;
    cyc();

    // Reset during MEM_WAIT
    hz_if.hz_l1d_req_in = 1'b1;
    cyc();
    expect_out("rw_wait", ODw);
    rst_n = 1'b0;
    expect_out("rw_async", ORst);
    hz_if.hz_l1d_req_in = 1'b0;
    cyc();
    #2;
    rst_n = 1'b1;
    cyc();
    expect_out("rw_after", ONone);

`ifdef CORE_HZRD_PERF_EN
    check("perf_stall_rst", {29'd0, stall_cnt}, 32'd0);
    check("perf_flush_rst", {29'd0, flush_cnt}, 32'd0);
    hz_if.hz_l1i_ack_in = 1'b0;
    repeat (4) cyc();
    hz_if.hz_l1i_ack_in = 1'b1;
    repeat (2) begin
      set_dec(1'b1, CmdJump, 5'd0, 1'b0);
      cyc();
      dec_idle();
      cyc();
    end
    cyc();
    check("perf_stall_4", {29'd0, stall_cnt}, 32'd4);
    check("perf_flush_2", {29'd0, flush_cnt}, 32'd2);
    hz_if.hz_l1i_ack_in = 1'b0;
    repeat (6) cyc();
    hz_if.hz_l1i_ack_in = 1'b1;
    cyc();
    check("perf_stall_sat", {29'd0, stall_cnt}, 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
